ide_channel_ctrl: RTL

IDE_CHANNEL_CTRL -- requirements
Module: ide_channel_ctrl

---
 rtl/ide_pkg.sv | 45 ++++
 rtl/ide_strobe_timer.sv | 37 +++
 rtl/ide_channel_ctrl.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ide_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ide_pkg
// Description : Shared definitions for the IDE channel controller: FSM state
//               encoding, bus-address field positions, default PIO timing
//               constants, the latched cycle descriptor and a helper that
//               turns a strobe length into a timer load value.
// Macros      : none
// Revision    : 1.0 - initial release
// ============================================================================
package ide_pkg;

    // FSM state encoding (kept as plain constants for legacy tools)
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SETUP  = 3'd1;
    localparam logic [2:0] ST_STROBE = 3'd2;
    localparam logic [2:0] ST_HOLD   = 3'd3;
    localparam logic [2:0] ST_ACK    = 3'd4;

    // Address field positions within ADDR[15:1]
    localparam int ADDR_SPACE_BIT = 15;  // 1 = IDE register space, 0 = ROM/config
    localparam int ADDR_CH_HI     = 14;  // channel field high bit
    localparam int ADDR_CH_LO     = 13;  // channel field low bit
    localparam int ADDR_CS_BIT    = 12;  // 0 = CS0, 1 = CS1

    // Default timing, in CLK cycles
    localparam int         DEF_SETUP_CYCLES = 1;
    localparam int         DEF_HOLD_CYCLES  = 1;
    localparam logic [3:0] DEF_STROBE       = 4'd3;

    // Everything about an accepted bus cycle that must outlive ADDR/RW
    typedef struct packed {
        logic       rw;   // 1 = read (IOR), 0 = write (IOW)
        logic       cs1;  // 1 = CS1 selected, 0 = CS0 selected
        logic [1:0] ch;   // channel, already reduced modulo CHANNELS
    } ide_cycle_t;

    // Timer load value for a strobe of 'len' cycles; a length of 0 is
    // stretched to a single cycle.
    function automatic logic [3:0] strobe_load(input logic [3:0] len);
        return (len == 4'd0) ? 4'd0 : len - 4'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ide_strobe_timer.sv
`default_nettype none
// ============================================================================
// Module      : ide_strobe_timer
// Description : Phase timer shared by the SETUP, STROBE and HOLD states.
//               Loading value N-1 makes done_o rise on the N-th cycle after
//               the load edge. The 4-bit down-counter saturates at zero.
// Ports       : clk, rst      - clock, synchronous active-high reset
//               load_i        - load load_val_i on the next edge
//               load_val_i    - phase length minus one
//               done_o        - counter has reached zero
// Macros      : none
// Revision    : 1.0 - initial release
// ============================================================================
module ide_strobe_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       load_i,
    input  logic [3:0] load_val_i,
    output logic       done_o
);

    logic [3:0] count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= 4'd0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (count_q != 4'd0) begin
            count_q <= count_q - 4'd1;
        end
    end

    assign done_o = (count_q == 4'd0);

endmodule
`default_nettype wire

// File: rtl/ide_channel_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ide_channel_ctrl
// Description : 68000-bus to multi-channel IDE PIO bridge. Synchronises AS_n,
//               decodes register vs ROM/config space, sequences
//               SETUP -> STROBE -> HOLD -> ACK for drive accesses and drives
//               registered chip selects, IOR_n/IOW_n and DTACK.
// Ports       : CLK, RESET                 - bus clock, sync active-high reset
//               ADDR[15:1]                 - bus address (15:12 decoded here)
//               AS_n, UDS_n, LDS_n, RW     - asynchronous 68000 strobes/direction
//               DIN[3:0]                   - write data D15:12
//               ide_access, ide_enable     - base match, board IDE enable
//               DTACK                      - cycle acknowledge
//               IOR_n, IOW_n               - shared IDE read/write strobes
//               IDE_CS0_n/IDE_CS1_n        - per-channel chip selects
//               IDE_ROMEN                  - boot-ROM overlay select
//               busy                       - controller not idle
// Macros      : IDE_PIO_TIMING_EN - per-channel strobe length registers,
//               written through ROM-space writes. Without it every channel
//               uses STROBE_DEFAULT.
// Revision    : 1.0 - initial release
// ============================================================================
module ide_channel_ctrl
    import ide_pkg::*;
#(
    parameter int         CHANNELS       = 2,
    parameter int         SETUP_CYCLES   = DEF_SETUP_CYCLES,
    parameter int         HOLD_CYCLES    = DEF_HOLD_CYCLES,
    parameter logic [3:0] STROBE_DEFAULT = DEF_STROBE
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic [15:1]         ADDR,
    input  logic                AS_n,
    input  logic                UDS_n,
    input  logic                LDS_n,
    input  logic                RW,
    input  logic [3:0]          DIN,
    input  logic                ide_access,
    input  logic                ide_enable,
    output logic                DTACK,
    output logic                IOR_n,
    output logic                IOW_n,
    output logic [CHANNELS-1:0] IDE_CS0_n,
    output logic [CHANNELS-1:0] IDE_CS1_n,
    output logic                IDE_ROMEN,
    output logic                busy
);

    localparam logic [3:0] SETUP_LD = 4'(SETUP_CYCLES - 1);
    localparam logic [3:0] HOLD_LD  = 4'(HOLD_CYCLES - 1);
    // CHANNELS is 1, 2 or 4, so masking implements the modulo
    localparam logic [1:0] CH_MASK  = 2'(CHANNELS - 1);

    // ------------------------------------------------------------------
    // AS_n synchroniser; every decision below uses as_sync_q only
    // ------------------------------------------------------------------
    logic as_meta_q;
    logic as_sync_q;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            as_meta_q <= 1'b1;
            as_sync_q <= 1'b1;
        end else begin
            as_meta_q <= AS_n;
            as_sync_q <= as_meta_q;
        end
    end

    // ------------------------------------------------------------------
    // Decode. ADDR/RW/DS are stable by the time the synchronised AS_n
    // is seen low, so they are sampled directly.
    // ------------------------------------------------------------------
    logic [1:0] w_addr_ch;
    logic       w_start;

    assign w_addr_ch = ADDR[ADDR_CH_HI:ADDR_CH_LO] & CH_MASK;
    assign w_start   = !as_sync_q && ide_access && ide_enable && (!UDS_n || !LDS_n);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [2:0]  state_q, state_d;
    ide_cycle_t  cyc_q, cyc_d;
    logic        romen_q, romen_d;
    logic        w_rom_wr;
    logic        w_timer_load;
    logic [3:0]  w_timer_val;
    logic        w_timer_done;
    logic [1:0]  w_sel_ch;
    logic [3:0]  w_sel_strobe;

    // In IDLE the new cycle's channel is not latched yet, so a start that
    // goes straight to STROBE must look up the strobe length from ADDR.
    assign w_sel_ch = (state_q == ST_IDLE) ? w_addr_ch : cyc_q.ch;

`ifdef IDE_PIO_TIMING_EN
    logic [3:0] strobe_q [CHANNELS];

    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < CHANNELS; i++) begin
                strobe_q[i] <= STROBE_DEFAULT;
            end
        end else if (w_rom_wr) begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (w_addr_ch == 2'(i)) begin
                    strobe_q[i] <= DIN;
                end
            end
        end
    end

    always_comb begin
        w_sel_strobe = STROBE_DEFAULT;
        for (int i = 0; i < CHANNELS; i++) begin
            if (w_sel_ch == 2'(i)) begin
                w_sel_strobe = strobe_q[i];
            end
        end
    end
`else
    assign w_sel_strobe = STROBE_DEFAULT;

    logic w_unused_cfg;
    assign w_unused_cfg = ^{DIN, w_sel_ch, w_rom_wr};
`endif

    // ADDR[11:1] belong to the drive register address, routed off-chip
    logic w_unused_addr;
    assign w_unused_addr = ^ADDR[11:1];

    ide_strobe_timer u_timer (
        .clk        (CLK),
        .rst        (RESET),
        .load_i     (w_timer_load),
        .load_val_i (w_timer_val),
        .done_o     (w_timer_done)
    );

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        cyc_d        = cyc_q;
        romen_d      = romen_q;
        w_rom_wr     = 1'b0;
        w_timer_load = 1'b0;
        w_timer_val  = 4'd0;

        case (state_q)
            ST_IDLE: begin
                if (w_start) begin
                    cyc_d.rw  = RW;
                    cyc_d.cs1 = ADDR[ADDR_CS_BIT];
                    cyc_d.ch  = w_addr_ch;
                    if (ADDR[ADDR_SPACE_BIT]) begin
                        w_timer_load = 1'b1;
                        if (SETUP_CYCLES > 0) begin
                            state_d     = ST_SETUP;
                            w_timer_val = SETUP_LD;
                        end else begin
                            state_d     = ST_STROBE;
                            w_timer_val = strobe_load(w_sel_strobe);
                        end
                    end else begin
                        // ROM/config space: reads just acknowledge
                        state_d = ST_ACK;
                        if (!RW) begin
                            romen_d  = 1'b0;
                            w_rom_wr = 1'b1;
                        end
                    end
                end
            end
            ST_SETUP: begin
                if (w_timer_done) begin
                    state_d      = ST_STROBE;
                    w_timer_load = 1'b1;
                    w_timer_val  = strobe_load(w_sel_strobe);
                end
            end
            ST_STROBE: begin
                if (w_timer_done) begin
                    if (HOLD_CYCLES > 0) begin
                        state_d      = ST_HOLD;
                        w_timer_load = 1'b1;
                        w_timer_val  = HOLD_LD;
                    end else begin
                        state_d = ST_ACK;
                    end
                end
            end
            ST_HOLD: begin
                if (w_timer_done) begin
                    state_d = ST_ACK;
                end
            end
            ST_ACK: begin
                // left only through the AS_n release below
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Released address strobe ends any cycle: normal end from ACK,
        // abort/bus error from anywhere else.
        if ((state_q != ST_IDLE) && as_sync_q) begin
            state_d = ST_IDLE;
        end
    end

    // ------------------------------------------------------------------
    // Outputs are decoded from the next state and registered so they
    // change on the same edge as the state itself.
    // ------------------------------------------------------------------
    logic                w_cs_active_d;
    logic [CHANNELS-1:0] w_cs0_n_d;
    logic [CHANNELS-1:0] w_cs1_n_d;

    assign w_cs_active_d = (state_d == ST_SETUP) || (state_d == ST_STROBE) ||
                           (state_d == ST_HOLD);

    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            w_cs0_n_d[i] = !(w_cs_active_d && (cyc_d.ch == 2'(i)) && !cyc_d.cs1);
            w_cs1_n_d[i] = !(w_cs_active_d && (cyc_d.ch == 2'(i)) &&  cyc_d.cs1);
        end
    end

    logic                dtack_q;
    logic                ior_n_q;
    logic                iow_n_q;
    logic                busy_q;
    logic [CHANNELS-1:0] cs0_n_q;
    logic [CHANNELS-1:0] cs1_n_q;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= ST_IDLE;
            cyc_q   <= '0;
            romen_q <= 1'b1;
            dtack_q <= 1'b0;
            ior_n_q <= 1'b1;
            iow_n_q <= 1'b1;
            busy_q  <= 1'b0;
            cs0_n_q <= '1;
            cs1_n_q <= '1;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            romen_q <= romen_d;
            dtack_q <= (state_d == ST_ACK);
            ior_n_q <= !((state_d == ST_STROBE) &&  cyc_d.rw);
            iow_n_q <= !((state_d == ST_STROBE) && !cyc_d.rw);
            busy_q  <= (state_d != ST_IDLE);
            cs0_n_q <= w_cs0_n_d;
            cs1_n_q <= w_cs1_n_d;
        end
    end

    assign DTACK     = dtack_q;
    assign IOR_n     = ior_n_q;
    assign IOW_n     = iow_n_q;
    assign busy      = busy_q;
    assign IDE_CS0_n = cs0_n_q;
    assign IDE_CS1_n = cs1_n_q;
    assign IDE_ROMEN = romen_q;

endmodule
`default_nettype wire
